// File: rtl/subtractor_64bit_seq.sv
// Multi-cycle 64-bit subtractor: inA - inB - inBorrow, one CHUNK_W slice per cycle, LSB first.
// Optional SUB64_FLAGS_EN adds registered zero/negative/signed-overflow flags.
module subtractor_64bit_seq #(
  parameter int CHUNK_W = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [63:0] inA,
  input  logic [63:0] inB,
  input  logic        inBorrow,
  input  logic        inValid,
  output logic        inReady,
  output logic [63:0] outDiff,
  output logic        outBorrow,
  output logic        outValid,
  input  logic        outReady
`ifdef SUB64_FLAGS_EN
  ,
  output logic        outZero,
  output logic        outNeg,
  output logic        outOverflow
`endif
);

  localparam int NUM_CHUNKS = 64 / CHUNK_W;
  localparam int IDX_W      = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1;

  // Handshakes: a transfer happens on a rising edge where valid && ready are both high;
  // inReady is high only in IDLE and outValid only in DONE, so accept and consume never coincide.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [63:0]      a_q, a_d;
  logic [63:0]      b_q, b_d;
  logic             carry_q, carry_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [63:0]      diff_q, diff_d;
  logic             borrow_q, borrow_d;
  logic             in_ready_q, in_ready_d;
  logic             out_valid_q, out_valid_d;
`ifdef SUB64_FLAGS_EN
  logic             zero_q, zero_d;
  logic             neg_q, neg_d;
  logic             ovf_q, ovf_d;
`endif

  logic [CHUNK_W-1:0] slice_a;
  logic [CHUNK_W-1:0] slice_b;
  logic [CHUNK_W:0]   slice_sum;
  logic [63:0]        diff_merged;

  // Subtraction is done as A + ~B + ~borrow; the carry out of each slice feeds the next.
  always_comb begin
    slice_a     = '0;
    slice_b     = '0;
    for (int i = 0; i < NUM_CHUNKS; i++) begin
      if (idx_q == IDX_W'(i)) begin
        slice_a = a_q[i*CHUNK_W +: CHUNK_W];
        slice_b = b_q[i*CHUNK_W +: CHUNK_W];
      end
    end
    slice_sum   = {1'b0, slice_a} + {1'b0, ~slice_b} + (CHUNK_W+1)'(carry_q);
    diff_merged = diff_q;
    for (int i = 0; i < NUM_CHUNKS; i++) begin
      if (idx_q == IDX_W'(i)) begin
        diff_merged[i*CHUNK_W +: CHUNK_W] = slice_sum[CHUNK_W-1:0];
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    b_d         = b_q;
    carry_d     = carry_q;
    idx_d       = idx_q;
    diff_d      = diff_q;
    borrow_d    = borrow_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
`ifdef SUB64_FLAGS_EN
    zero_d      = zero_q;
    neg_d       = neg_q;
    ovf_d       = ovf_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (inValid && in_ready_q) begin
          a_d        = inA;
          b_d        = inB;
          carry_d    = ~inBorrow;
          idx_d      = '0;
          in_ready_d = 1'b0;
          state_d    = ST_BUSY;
        end
      end
      ST_BUSY: begin
        diff_d  = diff_merged;
        carry_d = slice_sum[CHUNK_W];
        if (idx_q == IDX_W'(NUM_CHUNKS - 1)) begin
          borrow_d    = ~slice_sum[CHUNK_W];
          out_valid_d = 1'b1;
          state_d     = ST_DONE;
`ifdef SUB64_FLAGS_EN
          zero_d      = (diff_merged == 64'd0);
          neg_d       = diff_merged[63];
          ovf_d       = (a_q[63] != b_q[63]) && (diff_merged[63] != a_q[63]);
`endif
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      ST_DONE: begin
        if (outReady) begin
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
          state_d     = ST_IDLE;
        end
      end
      default: begin
        out_valid_d = 1'b0;
        in_ready_d  = 1'b1;
        state_d     = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      a_q         <= '0;
      b_q         <= '0;
      carry_q     <= 1'b0;
      idx_q       <= '0;
      diff_q      <= '0;
      borrow_q    <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
`ifdef SUB64_FLAGS_EN
      zero_q      <= 1'b0;
      neg_q       <= 1'b0;
      ovf_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      carry_q     <= carry_d;
      idx_q       <= idx_d;
      diff_q      <= diff_d;
      borrow_q    <= borrow_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
`ifdef SUB64_FLAGS_EN
      zero_q      <= zero_d;
      neg_q       <= neg_d;
      ovf_q       <= ovf_d;
`endif
    end
  end

  assign inReady   = in_ready_q;
  assign outDiff   = diff_q;
  assign outBorrow = borrow_q;
  assign outValid  = out_valid_q;
`ifdef SUB64_FLAGS_EN
  assign outZero     = zero_q;
  assign outNeg      = neg_q;
  assign outOverflow = ovf_q;
`endif

endmodule

// File: tb/tb_subtractor_64bit_seq.sv
// Bench for subtractor_64bit_seq: four instances (CHUNK_W = 16, 8, 32, 64) checked against
// a 65-bit arithmetic reference model.
module tb_subtractor_64bit_seq;

  logic        clk;
  logic        rst;
  logic [63:0] in_a      [4];
  logic [63:0] in_b      [4];
  logic        in_borrow [4];
  logic        in_valid  [4];
  logic        out_ready [4];
  logic        in_ready  [4];
  logic [63:0] out_diff  [4];
  logic        out_borrow[4];
  logic        out_valid [4];
`ifdef SUB64_FLAGS_EN
  logic        out_zero  [4];
  logic        out_neg   [4];
  logic        out_ovf   [4];
`endif

  int checks = 0;
  int errors = 0;

  for (genvar g = 0; g < 4; g++) begin : g_dut
    localparam int CW = (g == 0) ? 16 : (g == 1) ? 8 : (g == 2) ? 32 : 64;
    subtractor_64bit_seq #(.CHUNK_W(CW)) dut (
      .clk        (clk),
      .rst        (rst),
      .inA        (in_a[g]),
      .inB        (in_b[g]),
      .inBorrow   (in_borrow[g]),
      .inValid    (in_valid[g]),
      .inReady    (in_ready[g]),
      .outDiff    (out_diff[g]),
      .outBorrow  (out_borrow[g]),
      .outValid   (out_valid[g]),
      .outReady   (out_ready[g])
`ifdef SUB64_FLAGS_EN
      ,
      .outZero    (out_zero[g]),
      .outNeg     (out_neg[g]),
      .outOverflow(out_ovf[g])
`endif
    );
  end

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #3_000_000;
    $display("FAIL watchdog got simulation still running want finish");
    $fatal(1);
  end

  function automatic int num_chunks(input int k);
    int cw;
    cw = (k == 0) ? 16 : (k == 1) ? 8 : (k == 2) ? 32 : 64;
    return 64 / cw;
  endfunction

  // {borrow, diff} = {0,A} - {0,B} - borrow_in
  function automatic logic [64:0] ref_sub(input logic [63:0] a, input logic [63:0] b,
                                          input logic bin);
    return {1'b0, a} - {1'b0, b} - 65'(bin);
  endfunction

  function automatic logic [63:0] rand64();
    return {$urandom(), $urandom()};
  endfunction

  // driver: one complete operation on instance k (consumes the result if out_ready is high)
  task automatic run_op(input int k, input logic [63:0] a, input logic [63:0] b, input logic bin,
                        output logic [63:0] d, output logic bo, output int lat);
    int w;
    w = 0;
    while (!in_ready[k] && w < 50) begin
      @(posedge clk); #1;
      w++;
    end
    in_a[k] = a; in_b[k] = b; in_borrow[k] = bin; in_valid[k] = 1'b1;
    @(posedge clk); #1;
    in_valid[k] = 1'b0;
    in_a[k] = rand64(); in_b[k] = rand64(); in_borrow[k] = ~bin;
    lat = 0;
    while (!out_valid[k] && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
    checks++;
    if (!out_valid[k]) begin
      errors++;
      $display("FAIL op_timeout inst=%0d got outValid=0 want outValid=1 within 200 cycles", k);
    end
    d  = out_diff[k];
    bo = out_borrow[k];
    if (out_ready[k]) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    for (int k = 0; k < 4; k++) begin
      in_a[k] = '0; in_b[k] = '0; in_borrow[k] = 1'b0; in_valid[k] = 1'b0; out_ready[k] = 1'b1;
    end
    repeat (3) @(posedge clk);
    #1;
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (in_ready[k] !== 1'b1 || out_valid[k] !== 1'b0 || out_diff[k] !== 64'd0 ||
          out_borrow[k] !== 1'b0) begin
        errors++;
        $display("FAIL reset_values inst=%0d got rdy=%b vld=%b diff=%h bo=%b want 1 0 0 0",
                 k, in_ready[k], out_valid[k], out_diff[k], out_borrow[k]);
      end
    end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_directed();
    logic [63:0] d;
    logic        bo;
    int          lat;
    run_op(0, 64'h0000_0001_0000_0000, 64'h1, 1'b0, d, bo, lat);
    checks++;
    if (d !== 64'h0000_0000_FFFF_FFFF || bo !== 1'b0 || lat != 4) begin
      errors++;
      $display("FAIL dir_borrow_across got diff=%h bo=%b lat=%0d want 00000000ffffffff 0 4",
               d, bo, lat);
    end
    run_op(0, 64'h0, 64'h1, 1'b0, d, bo, lat);
    checks++;
    if (d !== 64'hFFFF_FFFF_FFFF_FFFF || bo !== 1'b1) begin
      errors++;
      $display("FAIL dir_zero_minus_one got diff=%h bo=%b want ffffffffffffffff 1", d, bo);
    end
    run_op(0, 64'h5, 64'h5, 1'b1, d, bo, lat);
    checks++;
    if (d !== 64'hFFFF_FFFF_FFFF_FFFF || bo !== 1'b1) begin
      errors++;
      $display("FAIL dir_equal_borrow_in got diff=%h bo=%b want ffffffffffffffff 1", d, bo);
    end
  endtask

  task automatic test_backpressure();
    logic [63:0] a, b, na, nb;
    logic [64:0] exp0, exp1;
    int          w;
    a = rand64(); b = rand64();
    na = rand64(); nb = rand64();
    exp0 = ref_sub(a, b, 1'b1);
    exp1 = ref_sub(na, nb, 1'b0);
    out_ready[0] = 1'b0;
    in_a[0] = a; in_b[0] = b; in_borrow[0] = 1'b1; in_valid[0] = 1'b1;
    @(posedge clk); #1;
    in_a[0] = na; in_b[0] = nb; in_borrow[0] = 1'b0;
    w = 0;
    while (!out_valid[0] && w < 50) begin
      @(posedge clk); #1;
      w++;
    end
    checks++;
    if (!out_valid[0] || {out_borrow[0], out_diff[0]} !== exp0) begin
      errors++;
      $display("FAIL bp_first_result got vld=%b bo=%b diff=%h want 1 %b %h",
               out_valid[0], out_borrow[0], out_diff[0], exp0[64], exp0[63:0]);
    end
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      checks++;
      if ({out_borrow[0], out_diff[0]} !== exp0 || in_ready[0] !== 1'b0 || out_valid[0] !== 1'b1) begin
        errors++;
        $display("FAIL bp_hold cyc=%0d got bo=%b diff=%h rdy=%b vld=%b want %b %h 0 1",
                 c, out_borrow[0], out_diff[0], in_ready[0], out_valid[0], exp0[64], exp0[63:0]);
      end
    end
    out_ready[0] = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (out_valid[0] !== 1'b0 || in_ready[0] !== 1'b1) begin
      errors++;
      $display("FAIL bp_release got vld=%b rdy=%b want 0 1", out_valid[0], in_ready[0]);
    end
    @(posedge clk); #1;
    in_valid[0] = 1'b0;
    checks++;
    if (in_ready[0] !== 1'b0) begin
      errors++;
      $display("FAIL bp_accept_next got rdy=%b want 0", in_ready[0]);
    end
    w = 0;
    while (!out_valid[0] && w < 50) begin
      @(posedge clk); #1;
      w++;
    end
    checks++;
    if (!out_valid[0] || {out_borrow[0], out_diff[0]} !== exp1 || w != 4) begin
      errors++;
      $display("FAIL bp_second_result got vld=%b bo=%b diff=%h lat=%0d want 1 %b %h 4",
               out_valid[0], out_borrow[0], out_diff[0], w, exp1[64], exp1[63:0]);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid();
    int seen;
    in_a[0] = 64'hDEAD_BEEF_0000_0001; in_b[0] = 64'h1; in_borrow[0] = 1'b0; in_valid[0] = 1'b1;
    @(posedge clk); #1;
    in_valid[0] = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checks++;
    if (out_valid[0] !== 1'b0 || out_diff[0] !== 64'd0 || out_borrow[0] !== 1'b0 ||
        in_ready[0] !== 1'b1) begin
      errors++;
      $display("FAIL reset_mid_busy got vld=%b diff=%h bo=%b rdy=%b want 0 0 0 1",
               out_valid[0], out_diff[0], out_borrow[0], in_ready[0]);
    end
    seen = 0;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      if (out_valid[0]) seen++;
    end
    checks++;
    if (seen != 0) begin
      errors++;
      $display("FAIL reset_mid_no_result got %0d valid cycles want 0", seen);
    end
  endtask

  // continuous inValid with operands changing every cycle; scoreboard holds expected results
  task automatic test_back_to_back();
    logic [64:0] exp_q[$];
    int          times[$];
    logic [64:0] e;
    in_valid[0] = 1'b1;
    in_a[0] = rand64(); in_b[0] = rand64(); in_borrow[0] = 1'($urandom_range(0, 1));
    for (int c = 0; c < 72; c++) begin
      if (c == 60) in_valid[0] = 1'b0;
      if (in_ready[0] && in_valid[0]) exp_q.push_back(ref_sub(in_a[0], in_b[0], in_borrow[0]));
      @(posedge clk); #1;
      if (out_valid[0]) begin
        times.push_back(c);
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL b2b_unexpected got result %h with empty queue want none", out_diff[0]);
        end else begin
          e = exp_q.pop_front();
          if ({out_borrow[0], out_diff[0]} !== e) begin
            errors++;
            $display("FAIL b2b_result got bo=%b diff=%h want %b %h",
                     out_borrow[0], out_diff[0], e[64], e[63:0]);
          end
        end
      end
      in_a[0] = rand64(); in_b[0] = rand64(); in_borrow[0] = 1'($urandom_range(0, 1));
    end
    checks++;
    if (exp_q.size() != 0 || times.size() != 10) begin
      errors++;
      $display("FAIL b2b_count got pending=%0d results=%0d want 0 10", exp_q.size(), times.size());
    end
    for (int i = 1; i < times.size(); i++) begin
      checks++;
      if (times[i] - times[i-1] != 6) begin
        errors++;
        $display("FAIL b2b_interval got %0d want 6", times[i] - times[i-1]);
      end
    end
  endtask

  task automatic test_sweep();
    logic [63:0] a, b, d;
    logic        bin, bo;
    logic [64:0] e;
    int          lat, n;
    for (int k = 0; k < 4; k++) begin
      n = (k == 0) ? 200 : 1000;
      for (int i = 0; i < n; i++) begin
        a = rand64(); b = rand64(); bin = 1'($urandom_range(0, 1));
        case ($urandom_range(0, 9))
          0: b = a;
          1: a = 64'd0;
          2: b = 64'hFFFF_FFFF_FFFF_FFFF;
          default: ;
        endcase
        e = ref_sub(a, b, bin);
        run_op(k, a, b, bin, d, bo, lat);
        checks++;
        if ({bo, d} !== e || lat != num_chunks(k)) begin
          errors++;
          $display("FAIL sweep inst=%0d a=%h b=%h bin=%b got bo=%b diff=%h lat=%0d want %b %h %0d",
                   k, a, b, bin, bo, d, lat, e[64], e[63:0], num_chunks(k));
        end
      end
    end
  endtask

`ifdef SUB64_FLAGS_EN
  task automatic test_flags();
    logic [63:0] a, b, d;
    logic        bin, bo, ez, en, eo;
    logic [64:0] e;
    int          lat;
    run_op(0, 64'h8000_0000_0000_0000, 64'h1, 1'b0, d, bo, lat);
    checks++;
    if (d !== 64'h7FFF_FFFF_FFFF_FFFF || out_ovf[0] !== 1'b1 || out_neg[0] !== 1'b0 ||
        out_zero[0] !== 1'b0 || bo !== 1'b0) begin
      errors++;
      $display("FAIL flags_overflow got diff=%h ovf=%b neg=%b zero=%b bo=%b want 7fffffffffffffff 1 0 0 0",
               d, out_ovf[0], out_neg[0], out_zero[0], bo);
    end
    run_op(0, 64'h1234, 64'h1234, 1'b0, d, bo, lat);
    checks++;
    if (out_zero[0] !== 1'b1 || out_ovf[0] !== 1'b0) begin
      errors++;
      $display("FAIL flags_zero got zero=%b ovf=%b want 1 0", out_zero[0], out_ovf[0]);
    end
    for (int i = 0; i < 100; i++) begin
      a = rand64(); b = (i % 8 == 0) ? a : rand64(); bin = 1'b0;
      e  = ref_sub(a, b, bin);
      ez = (e[63:0] == 64'd0);
      en = e[63];
      eo = (a[63] != b[63]) && (e[63] != a[63]);
      run_op(0, a, b, bin, d, bo, lat);
      checks++;
      if (out_zero[0] !== ez || out_neg[0] !== en || out_ovf[0] !== eo) begin
        errors++;
        $display("FAIL flags_random a=%h b=%h got z=%b n=%b o=%b want %b %b %b",
                 a, b, out_zero[0], out_neg[0], out_ovf[0], ez, en, eo);
      end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_directed();
    test_backpressure();
    test_reset_mid();
    test_back_to_back();
    test_sweep();
`ifdef SUB64_FLAGS_EN
    test_flags();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
